mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter N, default 16: fixed-point data width.
REQ-002 SHALL have parameter Q, default 8: fractional bits, carried for package consistency.
REQ-003 SHALL have parameter MAX_TAPS, default 25: maximum taps per window.
REQ-004 SHALL have parameter ADDR_W, default 5: tap address width; ADDR_W >= clog2(MAX_TAPS).
REQ-005 Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- start  in  1: request one window accumulation.
- num_taps  in  ADDR_W+1: tap count, sampled with start.
- busy  out  1: high from accepted start until the result handshake completes.
- rd_en  out  1: buffer read strobe.
- rd_addr  out  ADDR_W: shared pixel and weight buffer address.
- mac_clr  out  1: synchronous clear of the MAC accumulator.
- mac_en  out  1: MAC accumulate enable.
- mac_out  in  N signed: MAC accumulator value.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts result.
- out_data  out  N signed: window result.
- done  out  1: one-cycle pulse on result acceptance.

Function
REQ-006 SHALL implement states IDLE, CLEAR, RUN, DRAIN, CAPTURE, OUT.
REQ-007 IDLE: start=1 SHALL latch num_taps and go to CLEAR; start SHALL be ignored in all other states.
REQ-008 CLEAR: mac_clr=1 for exactly one cycle and rd_addr=0; next state is RUN, or DRAIN if latched num_taps=0.
REQ-009 RUN:
- rd_en=1 every cycle.
- rd_addr increments by 1 per cycle from 0 to num_taps-1.
- On the last address, next state is DRAIN.
REQ-010 Buffer read latency is 1 cycle: mac_en SHALL be rd_en delayed one cycle, giving exactly num_taps mac_en pulses per window.
REQ-011 DRAIN: rd_en=0; the final mac_en is asserted here; next state is CAPTURE.
REQ-012 CAPTURE: the result register SHALL load mac_out; next state is OUT.
REQ-013 OUT: out_valid=1 and out_data held stable until out_ready=1, then done=1 for that cycle and next state is IDLE.
REQ-014 Handshake: out_valid SHALL NOT drop without out_ready; out_ready while out_valid=0 SHALL have no effect.
REQ-015 Latency: with start accepted at edge 0 and out_ready held high, out_valid SHALL first assert num_taps+4 cycles later.
REQ-016 A new start in the same cycle as done SHALL be ignored (FSM is in OUT); earliest restart is the cycle after done.
REQ-017 num_taps > MAX_TAPS SHALL be saturated to MAX_TAPS at latch time.
REQ-018 num_taps=0 SHALL produce out_data=0 with mac_en never asserted.
REQ-019 busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 Reset asserted SHALL immediately force IDLE, with busy, rd_en, rd_addr, mac_clr, mac_en, out_valid, out_data and done all 0.
REQ-021 Reset mid-window SHALL abandon the window with no done and no out_valid; the first start after release SHALL run normally.

Configuration
REQ-022 With macro SEQ_RELU_EN defined, the CAPTURE load SHALL be max(0, mac_out), applying ReLU.
REQ-023 Without SEQ_RELU_EN, the CAPTURE load SHALL pass mac_out unmodified, negative values included.

Structure
REQ-024 The state enum, default N/Q/MAX_TAPS/ADDR_W constants, and the saturation helper SHALL reside in shared package cnn_pkg.
REQ-025 The tap address counter (clear, enable, terminal flag) SHALL be sub-module tap_counter; all else stays in mac_sequencer.

Verification
REQ-026 Bench SHALL pair the block with a behavioural Q8.8 MAC and a 1-cycle-latency buffer model.
REQ-027 num_taps=9, pixels 0x0100, weights 0x0080, out_ready=1 -> out_data=0x0480, out_valid at cycle 13, exactly 9 mac_en pulses.
REQ-028 num_taps=0 -> no mac_en, out_data=0x0000, done pulse at cycle 4.
REQ-029 num_taps=40 -> saturated to 25 mac_en pulses, final rd_addr=24.
REQ-030 num_taps=4 with products summing to -1.0, out_ready held 0 for 5 cycles -> out_data stable for all 5 cycles; value 0xFF00 without SEQ_RELU_EN, 0x0000 with it.
REQ-031 reset asserted while in RUN at rd_addr=3 -> all outputs 0 immediately; a following start with num_taps=2 completes correctly.
REQ-032 start pulsed during RUN and in the done cycle -> both ignored, no second window started.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN constants, MAC sequencer state encoding and the tap-count saturation helper.
package cnn_pkg;

  localparam int CNN_N        = 16;
  localparam int CNN_Q        = 8;
  localparam int CNN_MAX_TAPS = 25;
  localparam int CNN_ADDR_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_OUT     = 3'd5
  } seq_state_t;

  function automatic int sat_taps(input int req, input int max_taps);
    return (req > max_taps) ? max_taps : req;
  endfunction

endpackage

// File: rtl/tap_counter.sv
// Tap address counter: sync clear, count enable, terminal flag when count is the last tap (num_i-1).
module tap_counter
  import cnn_pkg::*;
#(
  parameter int ADDR_W = CNN_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [ADDR_W:0]   num_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              term_o
);

  logic [ADDR_W-1:0] count_d;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W:0]   count_p1;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Compared one bit wider so a full-width tap count never aliases to zero.
  assign count_p1 = {1'b0, count_q} + (ADDR_W + 1)'(1);
  assign term_o   = (count_p1 == num_i);
  assign count_o  = count_q;

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one window of buffer reads into an external MAC and hands the result out on valid/ready.
// Result valid num_taps+4 cycles after start is presented; SEQ_RELU_EN clamps negative results to zero.
module mac_sequencer
  import cnn_pkg::*;
#(
  parameter int N        = CNN_N,
  parameter int Q        = CNN_Q,
  parameter int MAX_TAPS = CNN_MAX_TAPS,
  parameter int ADDR_W   = CNN_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     num_taps,
  output logic                busy,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                mac_clr,
  output logic                mac_en,
  input  logic signed [N-1:0] mac_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_data,
  output logic                done
);

  if (Q >= N || (1 << ADDR_W) < MAX_TAPS) begin : g_param_check
    $error("mac_sequencer: Q must be below N and ADDR_W must address MAX_TAPS entries");
  end

  seq_state_t          state_q;
  logic [ADDR_W:0]     taps_q;
  logic                busy_q;
  logic                rd_en_q;
  logic                mac_clr_q;
  logic                mac_en_q;
  logic                out_valid_q;
  logic signed [N-1:0] out_data_q;
  logic signed [N-1:0] capture_val;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_term;
  logic [ADDR_W-1:0]   cnt_addr;

  assign cnt_clr = (state_q == S_IDLE) && start;
  assign cnt_en  = (state_q == S_RUN) && !cnt_term;

  tap_counter #(
    .ADDR_W (ADDR_W)
  ) u_tap_counter (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .num_i   (taps_q),
    .count_o (cnt_addr),
    .term_o  (cnt_term)
  );

`ifdef SEQ_RELU_EN
  assign capture_val = mac_out[N-1] ? '0 : mac_out;
`else
  assign capture_val = mac_out;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      taps_q      <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // Buffer data lands one cycle after the read strobe, so the MAC enable trails it.
      mac_en_q  <= rd_en_q;
      mac_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            taps_q    <= (ADDR_W + 1)'(sat_taps(int'(num_taps), MAX_TAPS));
            busy_q    <= 1'b1;
            mac_clr_q <= 1'b1;
            state_q   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (taps_q == '0) begin
            state_q <= S_DRAIN;
          end else begin
            rd_en_q <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_term) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          out_data_q  <= capture_val;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = cnt_addr;
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = out_valid_q && out_ready;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural Q8.8 MAC and one-cycle-latency pixel/weight buffers.
module tb_mac_sequencer;

  localparam int N        = 16;
  localparam int ADDR_W   = 5;
  localparam int MAX_TAPS = 25;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                out_ready = 1'b0;
  logic [ADDR_W:0]     num_taps = '0;
  logic                busy, rd_en, mac_clr, mac_en, out_valid, done;
  logic [ADDR_W-1:0]   rd_addr;
  logic signed [N-1:0] mac_out, out_data;

  logic signed [15:0]  pixel  [32];
  logic signed [15:0]  weight [32];
  logic signed [15:0]  pix_q = '0;
  logic signed [15:0]  w_q = '0;
  logic signed [15:0]  acc = '0;
  int                  mac_en_total = 0;
  int                  done_total = 0;
  logic [ADDR_W-1:0]   last_addr = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_sequencer #(
    .N        (N),
    .Q        (8),
    .MAX_TAPS (MAX_TAPS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_taps  (num_taps),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .mac_out   (mac_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
  );

  function automatic logic signed [15:0] q88_mul(input int a, input int b);
    int p;
    p = a * b;
    return 16'(p >>> 8);
  endfunction

  // Environment: buffers answer one cycle after rd_en, MAC accumulates on mac_en.
  always @(posedge clk) begin
    if (rd_en) begin
      pix_q     <= pixel[rd_addr];
      w_q       <= weight[rd_addr];
      last_addr <= rd_addr;
    end
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + q88_mul(pix_q, w_q);
    if (mac_en) mac_en_total <= mac_en_total + 1;
    if (done) done_total <= done_total + 1;
  end
  assign mac_out = acc;

  function automatic logic [15:0] ref_result(input int n);
    int sum;
    logic [15:0] r;
    sum = 0;
    for (int k = 0; k < n; k++) sum += q88_mul(pixel[k], weight[k]);
    r = 16'(sum);
`ifdef SEQ_RELU_EN
    if (r[15]) r = '0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [15:0] p, input logic [15:0] w);
    for (int k = 0; k < 32; k++) begin
      pixel[k]  = p;
      weight[k] = w;
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 32; k++) begin
      pixel[k]  = 16'($urandom_range(0, 65535));
      weight[k] = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, ":busy"}, busy, 0);
    check({nm, ":rd_en"}, rd_en, 0);
    check({nm, ":rd_addr"}, rd_addr, 0);
    check({nm, ":mac_clr"}, mac_clr, 0);
    check({nm, ":mac_en"}, mac_en, 0);
    check({nm, ":out_valid"}, out_valid, 0);
    check({nm, ":out_data"}, $unsigned(out_data), 0);
    check({nm, ":done"}, done, 0);
  endtask

  // Starts a window in the current cycle (called #1 after a rising edge).
  task automatic run_window(input string nm, input int n, input int hold, input bit poke);
    int n_eff, cyc, en0, dn0;
    logic [15:0] exp;
    n_eff     = (n > MAX_TAPS) ? MAX_TAPS : n;
    exp       = ref_result(n_eff);
    en0       = mac_en_total;
    dn0       = done_total;
    out_ready = (hold == 0);
    num_taps  = (ADDR_W + 1)'(n);
    start     = 1'b1;
    cyc       = 0;
    do begin
      tick();
      cyc++;
      start = poke && (cyc == 2);
    end while (!out_valid && cyc < 200);
    start = 1'b0;
    check({nm, ":valid_seen"}, out_valid, 1);
    if (!out_valid) return;
    check({nm, ":latency"}, cyc, n_eff + 4);
    check({nm, ":data"}, $unsigned(out_data), exp);
    if (hold == 0) check({nm, ":done_with_valid"}, done, 1);
    for (int i = 0; i < hold; i++) begin
      check({nm, ":hold_data"}, $unsigned(out_data), exp);
      check({nm, ":hold_valid"}, out_valid, 1);
      check({nm, ":hold_done"}, done, 0);
      tick();
    end
    out_ready = 1'b1;
    start     = poke;
    #1;
    check({nm, ":done"}, done, 1);
    tick();
    start = 1'b0;
    check({nm, ":valid_drop"}, out_valid, 0);
    check({nm, ":busy_drop"}, busy, 0);
    check({nm, ":done_count"}, done_total - dn0, 1);
    check({nm, ":mac_en_count"}, mac_en_total - en0, n_eff);
    if (n_eff > 0) check({nm, ":last_addr"}, last_addr, n_eff - 1);
    if (poke) begin
      tick();
      tick();
      check({nm, ":no_restart_busy"}, busy, 0);
      check({nm, ":no_restart_mac_en"}, mac_en_total - en0, n_eff);
    end
  endtask

  initial begin
    int cyc, dn0;
    fill_const(16'h0000, 16'h0000);
    tick();
    check_zero_outputs("reset");
    #4;
    reset = 1'b1;
    tick();

    fill_const(16'h0100, 16'h0080);
    run_window("taps9", 9, 0, 0);
    run_window("taps0", 0, 0, 0);
    fill_rand();
    run_window("taps40", 40, 0, 0);
    run_window("taps25", 25, 1, 0);
    run_window("taps1", 1, 0, 0);
    fill_const(16'h0100, 16'hFFC0);
    run_window("neg4", 4, 5, 0);

    for (int i = 0; i < 6; i++) begin
      fill_rand();
      run_window("rand", $urandom_range(0, 31), $urandom_range(0, 3), 0);
    end

    fill_rand();
    run_window("poke", 6, 0, 1);
    run_window("poke_hold", 6, 2, 1);

    // Abandon a window mid-RUN, then confirm a fresh one runs cleanly.
    fill_rand();
    out_ready = 1'b1;
    num_taps  = (ADDR_W + 1)'(8);
    start     = 1'b1;
    cyc       = 0;
    do begin
      tick();
      cyc++;
      start = 1'b0;
    end while (!(rd_en && rd_addr == 3) && cyc < 50);
    check("rst_point", rd_addr, 3);
    dn0   = done_total;
    reset = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_valid", out_valid, 0);
    end
    check("rst_no_done", done_total - dn0, 0);
    #3;
    reset = 1'b1;
    tick();
    run_window("post_rst", 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
